bit_slicer_fifo: RTL and testbench

BIT_SLICER_FIFO -- requirements
Module: bit_slicer_fifo

---
 rtl/bit_slicer_fifo.sv | 144 ++++++++++++++
 tb/tb_bit_slicer_fifo.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_slicer_fifo.sv
// bit_slicer_fifo: splits each accepted input flit into a data field and an
// address field and queues them in two independent output FIFOs.
//
// Ports:
//   clk, reset        single clock; asynchronous active-high reset
//   in_valid/in_ready input flit handshake; in_data carries address and data
//   data_valid/ready  data FIFO head handshake; data_out is the head entry
//   addr_valid/ready  address FIFO head handshake; addr_out is the head entry
//   flit_count        flits accepted since reset (16-bit, wraps)
//
// bit_slicer_fifo_buf is the per-field storage: a DEPTH-entry ring buffer
// with one extra pointer bit to tell full from empty.

module bit_slicer_fifo_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] rdata
);
  localparam int PW = $clog2(DEPTH);

  typedef logic [PW:0] ptr_t;

  ptr_t             wr_ptr;
  ptr_t             rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ptr_t'(1);
      if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
    end
  end

  // Storage needs no reset: the pointers alone decide what is visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= wdata;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign rdata = mem[rd_ptr[PW-1:0]];
endmodule

module bit_slicer_fifo #(
  parameter int DATA_W      = 7,
  parameter int ADDR_W      = 4,
  parameter int DEPTH       = 2,
  parameter int ADDR_AT_LSB = 1,
  localparam int IN_W       = DATA_W + ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  output logic              data_valid,
  input  logic              data_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] addr_out,
  output logic [15:0]       flit_count
);
  logic              run;
  logic              accept;
  logic              data_full;
  logic              data_empty;
  logic              addr_full;
  logic              addr_empty;
  logic              data_pop;
  logic              addr_pop;
  logic [DATA_W-1:0] data_field;
  logic [ADDR_W-1:0] addr_field;

  generate
    if (ADDR_AT_LSB != 0) begin : g_addr_lsb
      assign addr_field = in_data[ADDR_W-1:0];
      assign data_field = in_data[IN_W-1:ADDR_W];
    end else begin : g_addr_msb
      assign addr_field = in_data[IN_W-1:DATA_W];
      assign data_field = in_data[DATA_W-1:0];
    end
  endgenerate

  // Held low through reset so in_ready stays 0 while the pointers are
  // forced clear; rises on the first edge after release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) run <= 1'b0;
    else       run <= 1'b1;
  end

  // Readiness uses only registered fullness: a pop in the same cycle does
  // not open a slot for this cycle's flit.
  assign in_ready   = run && !data_full && !addr_full;
  assign accept     = in_valid && in_ready;
  assign data_valid = !data_empty;
  assign addr_valid = !addr_empty;
  assign data_pop   = data_valid && data_ready;
  assign addr_pop   = addr_valid && addr_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       flit_count <= '0;
    else if (accept) flit_count <= flit_count + 16'd1;
  end

  bit_slicer_fifo_buf #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_data_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .wdata (data_field),
    .pop   (data_pop),
    .full  (data_full),
    .empty (data_empty),
    .rdata (data_out)
  );

  bit_slicer_fifo_buf #(
    .WIDTH (ADDR_W),
    .DEPTH (DEPTH)
  ) u_addr_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .wdata (addr_field),
    .pop   (addr_pop),
    .full  (addr_full),
    .empty (addr_empty),
    .rdata (addr_out)
  );
endmodule

// File: tb/tb_bit_slicer_fifo.sv
module tb_bit_slicer_fifo;
  localparam int DW    = 7;
  localparam int AW    = 4;
  localparam int DEPTH = 2;
  localparam int IW    = DW + AW;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic [IW-1:0] in_data;
  logic          data_ready;
  logic          addr_ready;

  logic          in_ready,   s_in_ready;
  logic          data_valid, s_data_valid;
  logic [DW-1:0] data_out,   s_data_out;
  logic          addr_valid, s_addr_valid;
  logic [AW-1:0] addr_out,   s_addr_out;
  logic [15:0]   flit_count, s_flit_count;

  int checks = 0;
  int errors = 0;

  // Reference model: two queues of expected payloads, an accept counter and
  // a flag for "first edge after reset has happened".
  logic [DW-1:0] dq[$];
  logic [AW-1:0] aq[$];
  int            cnt;
  bit            m_run;

  bit_slicer_fifo #(
    .DATA_W      (DW),
    .ADDR_W      (AW),
    .DEPTH       (DEPTH),
    .ADDR_AT_LSB (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .data_out   (data_out),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .addr_out   (addr_out),
    .flit_count (flit_count)
  );

  bit_slicer_fifo #(
    .DATA_W      (DW),
    .ADDR_W      (AW),
    .DEPTH       (DEPTH),
    .ADDR_AT_LSB (0)
  ) dut_swap (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (s_in_ready),
    .in_data    (in_data),
    .data_valid (s_data_valid),
    .data_ready (data_ready),
    .data_out   (s_data_out),
    .addr_valid (s_addr_valid),
    .addr_ready (addr_ready),
    .addr_out   (s_addr_out),
    .flit_count (s_flit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge, applying the handshake rules to the model,
  // then return 1 time unit after the edge.
  task automatic tick();
    int unsigned dsz, asz;
    bit rdy;
    @(posedge clk);
    dsz = dq.size();
    asz = aq.size();
    rdy = m_run && (dsz < DEPTH) && (asz < DEPTH);
    if (dsz > 0 && data_ready) void'(dq.pop_front());
    if (asz > 0 && addr_ready) void'(aq.pop_front());
    if (in_valid && rdy) begin
      dq.push_back(DW'(in_data / (1 << AW)));
      aq.push_back(AW'(in_data % (1 << AW)));
      cnt = (cnt + 1) % 65536;
    end
    m_run = 1'b1;
    #1;
  endtask

  task automatic model_clear();
    dq.delete();
    aq.delete();
    cnt   = 0;
    m_run = 1'b0;
  endtask

  task automatic test_reset();
    in_valid   = 1'b0;
    in_data    = 'x;
    data_ready = 1'b0;
    addr_ready = 1'b0;
    reset      = 1'b1;
    model_clear();
    #3;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid got %b want 0", data_valid); end
    checks++; if (addr_valid !== 1'b0) begin errors++; $display("FAIL reset_addr_valid got %b want 0", addr_valid); end
    checks++; if (flit_count !== 16'd0) begin errors++; $display("FAIL reset_flit_count got %0d want 0", flit_count); end
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_single();
    data_ready = 1'b1;
    addr_ready = 1'b1;
    in_valid   = 1'b1;
    in_data    = 11'h5A3;
    #1;
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL single_no_bypass got %b want 0", data_valid); end
    tick();
    in_valid = 1'b0;
    in_data  = 'x;
    checks++; if (addr_valid !== 1'b1 || addr_out !== 4'h3) begin errors++; $display("FAIL single_addr got v=%b %h want v=1 3", addr_valid, addr_out); end
    checks++; if (data_valid !== 1'b1 || data_out !== 7'h5A) begin errors++; $display("FAIL single_data got v=%b %h want v=1 5a", data_valid, data_out); end
    checks++; if (flit_count !== 16'd1) begin errors++; $display("FAIL single_count got %0d want 1", flit_count); end
    tick();
    checks++; if (data_valid !== 1'b0 || addr_valid !== 1'b0) begin errors++; $display("FAIL single_one_cycle got dv=%b av=%b want 0 0", data_valid, addr_valid); end
  endtask

  task automatic test_field_swap();
    in_valid = 1'b1;
    in_data  = 11'h5A3;
    tick();
    in_valid = 1'b0;
    in_data  = 'x;
    checks++; if (s_addr_valid !== 1'b1 || s_addr_out !== 4'hB) begin errors++; $display("FAIL swap_addr got v=%b %h want v=1 b", s_addr_valid, s_addr_out); end
    checks++; if (s_data_valid !== 1'b1 || s_data_out !== 7'h23) begin errors++; $display("FAIL swap_data got v=%b %h want v=1 23", s_data_valid, s_data_out); end
    checks++; if (s_flit_count !== 16'd2 || s_in_ready !== 1'b1) begin errors++; $display("FAIL swap_count got %0d rdy=%b want 2 1", s_flit_count, s_in_ready); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [IW-1:0] f [3];
    int base;
    for (int i = 0; i < 3; i++) f[i] = IW'($urandom);
    base       = cnt;
    addr_ready = 1'b0;
    data_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = f[i];
      if (i > 0) begin
        checks++; if (data_valid !== 1'b1 || data_out !== DW'(f[i-1] >> AW)) begin errors++; $display("FAIL bp_data_drain%0d got v=%b %h want v=1 %h", i, data_valid, data_out, DW'(f[i-1] >> AW)); end
      end
      tick();
    end
    repeat (2) tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
    checks++; if (flit_count !== 16'(base + 2)) begin errors++; $display("FAIL bp_count got %0d want %0d", flit_count, 16'(base + 2)); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL bp_data_empty got %b want 0", data_valid); end
    in_valid   = 1'b0;
    in_data    = 'x;
    addr_ready = 1'b1;
    #1;
    checks++; if (addr_valid !== 1'b1 || addr_out !== AW'(f[0])) begin errors++; $display("FAIL bp_addr0 got v=%b %h want v=1 %h", addr_valid, addr_out, AW'(f[0])); end
    tick();
    checks++; if (addr_valid !== 1'b1 || addr_out !== AW'(f[1])) begin errors++; $display("FAIL bp_addr1 got v=%b %h want v=1 %h", addr_valid, addr_out, AW'(f[1])); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_reopen got %b want 1", in_ready); end
    tick();
    checks++; if (addr_valid !== 1'b0) begin errors++; $display("FAIL bp_addr_empty got %b want 0", addr_valid); end
  endtask

  task automatic test_mid_reset();
    data_ready = 1'b0;
    addr_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = IW'($urandom);
      tick();
    end
    in_valid = 1'b0;
    in_data  = 'x;
    checks++; if (data_valid !== 1'b1 || addr_valid !== 1'b1 || dq.size() != 2) begin errors++; $display("FAIL mr_buffered got dv=%b av=%b want 1 1", data_valid, addr_valid); end
    #2 reset = 1'b1;
    #1;
    checks++; if (data_valid !== 1'b0 || addr_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL mr_async got dv=%b av=%b rdy=%b want 0 0 0", data_valid, addr_valid, in_ready); end
    model_clear();
    @(posedge clk);
    #3 reset = 1'b0;
    data_ready = 1'b1;
    addr_ready = 1'b1;
    tick();
    checks++; if (data_valid !== 1'b0 || addr_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL mr_release got dv=%b av=%b rdy=%b want 0 0 1", data_valid, addr_valid, in_ready); end
    checks++; if (flit_count !== 16'd0) begin errors++; $display("FAIL mr_count got %0d want 0", flit_count); end
  endtask

  task automatic test_streaming();
    int  accepted = 0;
    int  cycles   = 0;
    bit  exp_rdy;
    in_valid = 1'b1;
    in_data  = IW'($urandom);
    while (accepted < 100 && cycles < 3000) begin
      data_ready = 1'($urandom);
      addr_ready = 1'($urandom);
      #1;
      exp_rdy = m_run && (dq.size() < DEPTH) && (aq.size() < DEPTH);
      checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL stream_ready cyc %0d got %b want %b", cycles, in_ready, exp_rdy); end
      checks++; if (data_valid !== (dq.size() != 0) || (dq.size() != 0 && data_out !== dq[0])) begin errors++; $display("FAIL stream_data cyc %0d got v=%b %h want v=%b %h", cycles, data_valid, data_out, dq.size() != 0, (dq.size() != 0) ? dq[0] : '0); end
      checks++; if (addr_valid !== (aq.size() != 0) || (aq.size() != 0 && addr_out !== aq[0])) begin errors++; $display("FAIL stream_addr cyc %0d got v=%b %h want v=%b %h", cycles, addr_valid, addr_out, aq.size() != 0, (aq.size() != 0) ? aq[0] : '0); end
      tick();
      cycles++;
      if (exp_rdy) begin
        accepted++;
        in_data = IW'($urandom);
      end
    end
    checks++; if (accepted != 100) begin errors++; $display("FAIL stream_timeout accepted %0d want 100", accepted); end
    in_valid   = 1'b0;
    in_data    = 'x;
    data_ready = 1'b1;
    addr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if ((dq.size() != 0 && data_out !== dq[0]) || (aq.size() != 0 && addr_out !== aq[0])) begin errors++; $display("FAIL stream_drain%0d got %h %h", i, data_out, addr_out); end
      tick();
    end
    checks++; if (data_valid !== 1'b0 || addr_valid !== 1'b0) begin errors++; $display("FAIL stream_empty got dv=%b av=%b want 0 0", data_valid, addr_valid); end
    checks++; if (flit_count !== 16'd100) begin errors++; $display("FAIL stream_count got %0d want 100", flit_count); end
  endtask

  task automatic test_wrap();
    reset = 1'b1;
    model_clear();
    @(posedge clk);
    #2 reset = 1'b0;
    tick();
    data_ready = 1'b1;
    addr_ready = 1'b1;
    in_valid   = 1'b1;
    in_data    = IW'($urandom);
    repeat (65535) tick();
    checks++; if (flit_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_max got %h want ffff", flit_count); end
    tick();
    checks++; if (flit_count !== 16'h0000) begin errors++; $display("FAIL wrap_zero got %h want 0000", flit_count); end
    in_valid = 1'b0;
    in_data  = 'x;
  endtask

  initial begin
    test_reset();
    test_single();
    test_field_swap();
    test_backpressure();
    test_mid_reset();
    test_streaming();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
